// File: rtl/reorder_buffer_if.sv
// Handshake bundle between the issue/execute pipeline and the reorder buffer:
// allocation, writeback, register-file update and front-end redirect.
interface reorder_buffer_if;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;

    logic        wb_valid;
    logic [3:0]  wb_tag;
    logic [31:0] wb_value;
    logic        wb_mispredict;
    logic [31:0] wb_target;

    logic        rf_rename_en;
    logic [4:0]  rf_rename_addr;
    logic [36:0] rf_rename_data;
    logic        rf_commit_en;
    logic [4:0]  rf_commit_addr;
    logic [36:0] rf_commit_data;
    logic        rf_flush;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output alloc_valid, alloc_rd, wb_valid, wb_tag, wb_value, wb_mispredict, wb_target,
        input  alloc_ready, alloc_tag, rf_rename_en, rf_rename_addr, rf_rename_data,
        input  rf_commit_en, rf_commit_addr, rf_commit_data, rf_flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  alloc_valid, alloc_rd, wb_valid, wb_tag, wb_value, wb_mispredict, wb_target,
        output alloc_ready, alloc_tag, rf_rename_en, rf_rename_addr, rf_rename_data,
        output rf_commit_en, rf_commit_addr, rf_commit_data, rf_flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// 16-entry in-order-retire reorder buffer: allocates at tail, completes by tag,
// retires from head, and flushes everything for one cycle after a mispredict retires.
module reorder_buffer #(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    reorder_buffer_if.slave   rob
);
    typedef enum logic {RUN, FLUSH} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        head_reg, tail_reg;
    logic [4:0]        count_reg;
    logic [DEPTH-1:0]  valid_reg, done_reg;
    logic [31:0]       redirect_pc_reg;

    logic [4:0]        rd_mem         [DEPTH];
    logic [31:0]       value_mem      [DEPTH];
    logic              mispredict_mem [DEPTH];
    logic [31:0]       target_mem     [DEPTH];

    logic              run_en, flush_active;
    logic              alloc_ready, alloc_fire, wb_fire, commit_fire;
    logic [4:0]        head_rd;
    logic [DEPTH-1:0]  same_rd_hit;
    logic              younger_found;
    logic [3:0]        younger_tag;

    assign run_en       = rst_n && rdy && (state_reg == RUN);
    assign flush_active = rst_n && rdy && (state_reg == FLUSH);
    assign alloc_ready  = run_en && (count_reg < 5'(DEPTH));
    assign alloc_fire   = alloc_ready && rob.alloc_valid;
    assign wb_fire      = run_en && rob.wb_valid && valid_reg[rob.wb_tag];
    assign commit_fire  = run_en && (count_reg != 5'd0) && valid_reg[head_reg] && done_reg[head_reg];
    assign head_rd      = rd_mem[head_reg];

    // Offset k from head marks a live entry that also writes the retiring register.
    assign same_rd_hit[0] = 1'b0;
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_scan
        logic [3:0] idx;
        assign idx = head_reg + 4'(gi);
        assign same_rd_hit[gi] = (5'(gi) < count_reg) && valid_reg[idx] && (rd_mem[idx] == head_rd);
    end

    // Highest offset wins, i.e. the youngest matching entry.
    always_comb begin
        younger_found = 1'b0;
        younger_tag   = 4'd0;
        for (int k = 1; k < DEPTH; k++) begin
            if (same_rd_hit[k]) begin
                younger_found = 1'b1;
                younger_tag   = head_reg + 4'(k);
            end
        end
    end

    assign rob.alloc_ready    = alloc_ready;
    assign rob.alloc_tag      = tail_reg;
    assign rob.rf_rename_en   = alloc_fire && (rob.alloc_rd != 5'd0);
    assign rob.rf_rename_addr = rob.alloc_rd;
    assign rob.rf_rename_data = {1'b1, tail_reg, 32'd0};
    assign rob.rf_commit_en   = commit_fire && (head_rd != 5'd0);
    assign rob.rf_commit_addr = head_rd;
    assign rob.rf_commit_data = {younger_found, younger_tag, value_mem[head_reg]};
    assign rob.rf_flush       = flush_active;
    assign rob.redirect_valid = flush_active;
    assign rob.redirect_pc    = redirect_pc_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (commit_fire && mispredict_mem[head_reg]) state_next = FLUSH;
            FLUSH:   if (rdy) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg        <= 4'd0;
            tail_reg        <= 4'd0;
            count_reg       <= 5'd0;
            redirect_pc_reg <= 32'd0;
        end else if (flush_active) begin
            head_reg  <= 4'd0;
            tail_reg  <= 4'd0;
            count_reg <= 5'd0;
        end else begin
            if (alloc_fire)  tail_reg <= tail_reg + 4'd1;
            if (commit_fire) head_reg <= head_reg + 4'd1;
            count_reg <= count_reg + 5'(alloc_fire) - 5'(commit_fire);
            if (commit_fire && mispredict_mem[head_reg]) redirect_pc_reg <= target_mem[head_reg];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            done_reg  <= '0;
        end else if (flush_active) begin
            valid_reg <= '0;
        end else begin
            if (commit_fire) valid_reg[head_reg] <= 1'b0;
            if (alloc_fire) begin
                valid_reg[tail_reg] <= 1'b1;
                done_reg[tail_reg]  <= 1'b0;
            end
            if (wb_fire) done_reg[rob.wb_tag] <= 1'b1;
        end
    end

    // Payload fields need no reset; they are only observed behind valid/done.
    always_ff @(posedge clk) begin
        if (alloc_fire) rd_mem[tail_reg] <= rob.alloc_rd;
        if (wb_fire) begin
            value_mem[rob.wb_tag]      <= rob.wb_value;
            mispredict_mem[rob.wb_tag] <= rob.wb_mispredict;
            target_mem[rob.wb_tag]     <= rob.wb_target;
        end
    end
endmodule
